// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : 2R/2W register file with write-to-read bypass and busy scoreboard
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
   parameter int XLEN     = 64,
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            we0,
   input  logic [AW-1:0]   wa0,
   input  logic [XLEN-1:0] wd0,
   input  logic            we1,
   input  logic [AW-1:0]   wa1,
   input  logic [XLEN-1:0] wd1,
   input  logic            alloc_en,
   input  logic [AW-1:0]   alloc_rd,
   output logic            busy_any
);

   localparam bit c_HARD_ZERO = (ZERO_REG != 0);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;

   logic w_wv0;
   logic w_wv1;
   logic w_av;
   logic w_rel1;
   logic w_rel2;

   // Writes and allocations aimed at a hardwired register 0 are dropped.
   assign w_wv0 = we0 && !(c_HARD_ZERO && (wa0 == '0));
   assign w_wv1 = we1 && !(c_HARD_ZERO && (wa1 == '0));
   assign w_av  = alloc_en && !(c_HARD_ZERO && (alloc_rd == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         // Port 1 is assigned last so it wins an address collision.
         if (w_wv0) r_regs[wa0] <= wd0;
         if (w_wv1) r_regs[wa1] <= wd1;
         for (int i = 0; i < NREGS; i++) begin
            if (w_av && (alloc_rd == AW'(i))) begin
               r_busy[i] <= 1'b1;
            end else if ((w_wv0 && (wa0 == AW'(i))) || (w_wv1 && (wa1 == AW'(i)))) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   assign rd1 = (c_HARD_ZERO && (rs1 == '0)) ? '0  :
                (we1 && (wa1 == rs1))        ? wd1 :
                (we0 && (wa0 == rs1))        ? wd0 : r_regs[rs1];
   assign rd2 = (c_HARD_ZERO && (rs2 == '0)) ? '0  :
                (we1 && (wa1 == rs2))        ? wd1 :
                (we0 && (wa0 == rs2))        ? wd0 : r_regs[rs2];

   // A same-cycle release is bypassed; a same-cycle allocation is not.
   assign w_rel1 = ((w_wv0 && (wa0 == rs1)) || (w_wv1 && (wa1 == rs1)))
                   && !(alloc_en && (alloc_rd == rs1));
   assign w_rel2 = ((w_wv0 && (wa0 == rs2)) || (w_wv1 && (wa1 == rs2)))
                   && !(alloc_en && (alloc_rd == rs2));

   assign rs1_busy = r_busy[rs1] && !w_rel1;
   assign rs2_busy = r_busy[rs2] && !w_rel2;
   assign busy_any = |r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : scoreboard bench for regfile_sb (ZERO_REG=1 and ZERO_REG=0)
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

   typedef struct packed {
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic        b1;
      logic        b2;
      logic        ba;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1, rs2, wa0, wa1, alloc_rd;
   logic [63:0] wd0, wd1;
   logic        we0, we1, alloc_en;

   logic [63:0] rd1_z, rd2_z, rd1_n, rd2_n;
   logic        b1_z, b2_z, ba_z, b1_n, b2_n, ba_n;

   int total = 0;
   int bad   = 0;

   exp_t q_z[$];
   exp_t q_n[$];

   // Reference state: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
   logic [63:0] mreg  [2][32];
   bit          mbusy [2][32];

   regfile_sb #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(1)) u_zr (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1_z), .rd2(rd2_z),
      .rs1_busy(b1_z), .rs2_busy(b2_z), .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
      .busy_any(ba_z));

   regfile_sb #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(0)) u_nz (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1_n), .rd2(rd2_n),
      .rs1_busy(b1_n), .rs2_busy(b2_n), .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
      .busy_any(ba_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_wvalid(int d, logic en, logic [4:0] a);
      return en && !(d == 0 && a == 5'd0);
   endfunction

   function automatic logic [63:0] m_rd(int d, logic [4:0] rs);
      if (d == 0 && rs == 5'd0) return 64'd0;
      if (we1 && wa1 == rs)     return wd1;
      if (we0 && wa0 == rs)     return wd0;
      return mreg[d][rs];
   endfunction

   function automatic logic m_busy(int d, logic [4:0] rs);
      bit released;
      bit alloc_same;
      released   = (m_wvalid(d, we0, wa0) && wa0 == rs) || (m_wvalid(d, we1, wa1) && wa1 == rs);
      alloc_same = alloc_en && alloc_rd == rs;
      return mbusy[d][rs] && !(released && !alloc_same);
   endfunction

   function automatic exp_t m_exp(int d);
      exp_t e;
      e.rd1 = m_rd(d, rs1);
      e.rd2 = m_rd(d, rs2);
      e.b1  = m_busy(d, rs1);
      e.b2  = m_busy(d, rs2);
      e.ba  = 1'b0;
      for (int i = 0; i < 32; i++) if (mbusy[d][i]) e.ba = 1'b1;
      return e;
   endfunction

   task automatic m_clear();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32; i++) begin
            mreg[d][i]  = 64'd0;
            mbusy[d][i] = 1'b0;
         end
   endtask

   task automatic m_commit();
      for (int d = 0; d < 2; d++) begin
         if (m_wvalid(d, we0, wa0)) begin mreg[d][wa0] = wd0; mbusy[d][wa0] = 1'b0; end
         if (m_wvalid(d, we1, wa1)) begin mreg[d][wa1] = wd1; mbusy[d][wa1] = 1'b0; end
         if (m_wvalid(d, alloc_en, alloc_rd)) mbusy[d][alloc_rd] = 1'b1;
      end
   endtask

   // One cycle: drive at the falling edge (an rst rise here is asynchronous),
   // queue the expected outputs, then advance the model at the rising edge.
   task automatic cyc(input logic r, input logic w0, input logic [4:0] a0, input logic [63:0] d0,
                      input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                      input logic ae, input logic [4:0] ar, input logic [4:0] s1, input logic [4:0] s2);
      @(negedge clk);
      rst = r; we0 = w0; wa0 = a0; wd0 = d0; we1 = w1; wa1 = a1; wd1 = d1;
      alloc_en = ae; alloc_rd = ar; rs1 = s1; rs2 = s2;
      if (r) m_clear();
      q_z.push_back(m_exp(0));
      q_n.push_back(m_exp(1));
      @(posedge clk);
      if (!r) m_commit();
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Monitor: outputs are combinational, so every queued entry is compared
   // against the DUT a little after the inputs settle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (q_z.size() > 0) begin
            e = q_z.pop_front();
            chk("rd1_zr", rd1_z, e.rd1);
            chk("rd2_zr", rd2_z, e.rd2);
            chk("rs1_busy_zr", {63'd0, b1_z}, {63'd0, e.b1});
            chk("rs2_busy_zr", {63'd0, b2_z}, {63'd0, e.b2});
            chk("busy_any_zr", {63'd0, ba_z}, {63'd0, e.ba});
         end
         while (q_n.size() > 0) begin
            e = q_n.pop_front();
            chk("rd1_nz", rd1_n, e.rd1);
            chk("rd2_nz", rd2_n, e.rd2);
            chk("rs1_busy_nz", {63'd0, b1_n}, {63'd0, e.b1});
            chk("rs2_busy_nz", {63'd0, b2_n}, {63'd0, e.b2});
            chk("busy_any_nz", {63'd0, ba_n}, {63'd0, e.ba});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; we0 = 0; we1 = 0; alloc_en = 0;
      wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; alloc_rd = 0; rs1 = 0; rs2 = 0;
      m_clear();

      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 12);
      // Load reg 5 and allocate reg 12, then reset mid-cycle.
      cyc(0, 1, 5, 64'h1234, 0, 0, 0, 1, 12, 5, 12);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 12);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 12);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 12);
      // Bypass then storage.
      cyc(0, 1, 7, 64'hDEAD, 0, 0, 0, 0, 0, 7, 7);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 6);
      // Port 1 beats port 0.
      cyc(0, 1, 3, 64'h11, 1, 3, 64'h22, 0, 0, 3, 3);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3);
      // Register 0 write and allocation.
      cyc(0, 1, 0, 64'hFFFF, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      // Scoreboard on reg 9.
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1);
      cyc(0, 0, 0, 0, 1, 9, 64'h99, 0, 0, 9, 9);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
      cyc(0, 1, 9, 64'h5, 0, 0, 0, 1, 9, 9, 9);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

      for (int n = 0; n < 10000; n++) begin
         cyc($urandom_range(0, 99) == 0,
             1'($urandom), 5'($urandom), {$urandom, $urandom},
             1'($urandom), 5'($urandom), {$urandom, $urandom},
             $urandom_range(0, 2) == 0, 5'($urandom),
             5'($urandom), 5'($urandom));
      end

      repeat (3) @(negedge clk);
      #4;
      total++;
      if (q_z.size() != 0 || q_n.size() != 0) begin
         bad++;
         $display("FAIL drain: actual=%0d expected=0 entries left", q_z.size() + q_n.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
